// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared definitions for the QoS weighted round-robin read scheduler:
// default sizing, state encoding and the weight loaded at reset.
package qos_wrr_scheduler_pkg;

    localparam int unsigned QUEUE_QUANTITY = 4;
    localparam int unsigned WEIGHT_WIDTH   = 3;
    localparam int unsigned DEFAULT_WEIGHT = 1;

    typedef enum logic {
        StIdle  = 1'b0,
        StServe = 1'b1
    } state_e;

endpackage

// File: rtl/qos_wrr_scheduler_next_eligible.sv
// Rotating-priority search: first set bit of eligible at or after start, wrapping.
// The wrap relies on the queue count being a power of two.
module qos_wrr_scheduler_next_eligible #(
    parameter int unsigned QUEUE_QUANTITY = 4
) (
    input  logic [QUEUE_QUANTITY-1:0]         eligible,
    input  logic [$clog2(QUEUE_QUANTITY)-1:0] start,
    output logic                              found,
    output logic [$clog2(QUEUE_QUANTITY)-1:0] index
);

    localparam int unsigned SelW = $clog2(QUEUE_QUANTITY);

    logic [SelW-1:0] pos;

    // Scan farthest-first so the nearest eligible entry wins the last write.
    always_comb begin
        found = 1'b0;
        index = start;
        pos   = '0;
        for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
            pos = start + SelW'(k);
            if (eligible[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin read scheduler for the VC FIFOs: drives rd_en, and a
// registered mux selector/valid aligned with the FIFO read data.
module qos_wrr_scheduler
    import qos_wrr_scheduler_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = qos_wrr_scheduler_pkg::QUEUE_QUANTITY,
    parameter int unsigned WEIGHT_WIDTH   = qos_wrr_scheduler_pkg::WEIGHT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enb,
    input  logic                                   init,
    input  logic [QUEUE_QUANTITY*WEIGHT_WIDTH-1:0] weights,
    input  logic [QUEUE_QUANTITY-1:0]              buf_empty,
    input  logic                                   pause,
    output logic [QUEUE_QUANTITY-1:0]              rd_en,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]      selector,
    output logic                                   selector_enb,
    output logic                                   idle
);

    localparam int unsigned SelW = $clog2(QUEUE_QUANTITY);

    state_e                                     state_q, state_d;
    logic [SelW-1:0]                            cur_q, cur_d;
    logic [SelW-1:0]                            ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0]                    credit_q, credit_d;
    logic [QUEUE_QUANTITY-1:0][WEIGHT_WIDTH-1:0] weight_q;

    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [SelW-1:0]           search_start;
    logic                      search_found;
    logic [SelW-1:0]           search_index;
    logic                      read_ok;
    logic                      advance;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = ~buf_empty[i] & (weight_q[i] != '0);
        end
    end

    // One shared search: from ptr when idle, from the VC after cur when serving,
    // so cur itself is considered last and a lone eligible VC is re-granted.
    assign search_start = (state_q == StIdle) ? ptr_q : cur_q + SelW'(1);

    qos_wrr_scheduler_next_eligible #(
        .QUEUE_QUANTITY(QUEUE_QUANTITY)
    ) u_next_eligible (
        .eligible(eligible),
        .start   (search_start),
        .found   (search_found),
        .index   (search_index)
    );

    assign read_ok = enb & ~init & ~pause & (state_q == StServe) & ~buf_empty[cur_q];
    assign rd_en   = read_ok ? (QUEUE_QUANTITY'(1) << cur_q) : '0;
    assign idle    = (state_q == StIdle) & (&buf_empty);

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        advance  = 1'b0;

        if (init) begin
            state_d  = StIdle;
            ptr_d    = '0;
            credit_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (search_found) begin
                        cur_d    = search_index;
                        credit_d = weight_q[search_index];
                        state_d  = StServe;
                    end
                end
                StServe: begin
                    if (!pause) begin
                        if (read_ok) begin
                            credit_d = credit_q - WEIGHT_WIDTH'(1);
                            advance  = (credit_q <= WEIGHT_WIDTH'(1));
                        end else begin
                            // Empty FIFO: forfeit the remaining credit.
                            advance = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (advance) begin
                if (search_found) begin
                    cur_d    = search_index;
                    credit_d = weight_q[search_index];
                end else begin
                    state_d  = StIdle;
                    ptr_d    = cur_q + SelW'(1);
                    credit_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            ptr_q        <= '0;
            credit_q     <= '0;
            selector     <= '0;
            selector_enb <= 1'b0;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                weight_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
            end
        end else if (enb) begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            selector_enb <= |rd_en;
            if (|rd_en) begin
                selector <= cur_q;
            end
            if (init) begin
                weight_q <= weights;
            end
        end
    end

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Scoreboard bench: directed scenarios push expected VC order; a negedge monitor
// pops and compares whenever selector_enb is high. FIFOs are modelled as counters.
module tb_qos_wrr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb;
    logic        init;
    logic        pause;
    logic [11:0] weights;
    logic [3:0]  buf_empty;
    logic [3:0]  rd_en;
    logic [1:0]  selector;
    logic        selector_enb;
    logic        idle;

    int   cnt[4] = '{default: 0};
    int   load_val[4];
    logic load;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    qos_wrr_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .init        (init),
        .weights     (weights),
        .buf_empty   (buf_empty),
        .pause       (pause),
        .rd_en       (rd_en),
        .selector    (selector),
        .selector_enb(selector_enb),
        .idle        (idle)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) buf_empty[i] = (cnt[i] == 0);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (load) cnt[i] <= load_val[i];
            else if (rd_en[i] && cnt[i] > 0) cnt[i] <= cnt[i] - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && selector_enb === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: selector=%0d, expected no read", selector);
            end else begin
                check("sel_order", 32'(selector), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [11:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {w3[2:0], w2[2:0], w1[2:0], w0[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        load_val[0] = c0;
        load_val[1] = c1;
        load_val[2] = c2;
        load_val[3] = c3;
    endtask

    // Init cycle with new weights and FIFO fill; returns in the following IDLE cycle.
    task automatic start_test(input logic [11:0] w, input int c0, input int c1, input int c2,
                              input int c3);
        init    = 1'b1;
        weights = w;
        set_counts(c0, c1, c2, c3);
        load = 1'b1;
        tick();
        init = 1'b0;
        load = 1'b0;
        #1;
    endtask

    task automatic drain(input string name);
        int budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (4) tick();
        check({name, "_drain"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        enb     = 1'b1;
        init    = 1'b0;
        pause   = 1'b0;
        weights = '0;
        load    = 1'b0;
        set_counts(0, 0, 0, 0);
        #2;
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_selector", 32'(selector), 0);
        check("rst_selector_enb", 32'(selector_enb), 0);
        check("rst_idle", 32'(idle), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Async reset mid-SERVE with default weights 1: vc0/vc1 alternate.
        set_counts(5, 5, 0, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        check("t1_idle_cycle", 32'(rd_en), 0);
        exp_q.push_back(0);
        tick();
        check("t1_rd0", 32'(rd_en), 4'b0001);
        tick();
        check("t1_rd1", 32'(rd_en), 4'b0010);
        tick();
        check("t1_rd2", 32'(rd_en), 4'b0001);
        check("t1_pre_rst_sel", 32'(selector), 1);
        #1 rst = 1'b1;
        #1;
        check("t1_async_rd_en", 32'(rd_en), 0);
        check("t1_async_selector", 32'(selector), 0);
        check("t1_async_selector_enb", 32'(selector_enb), 0);
        set_counts(0, 0, 0, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        check("t1_idle_after_rst", 32'(idle), 1);
        check("t1_queue", 32'(exp_q.size()), 0);
        exp_q.delete();
        rst = 1'b0;
        tick();

        // Equal weights, 3 words each: 0,1,2,3 three times.
        start_test(pack_w(1, 1, 1, 1), 3, 3, 3, 3);
        for (int r = 0; r < 3; r++)
            for (int v = 0; v < 4; v++) exp_q.push_back(v);
        check("t2_idle_cycle", 32'(rd_en), 0);
        tick();
        check("t2_first", 32'(rd_en), 4'b0001);
        tick();
        check("t2_second", 32'(rd_en), 4'b0010);
        drain("t2");
        check("t2_idle", 32'(idle), 1);

        // Weights 3,1,0,0: vc2/vc3 never read despite data.
        start_test(pack_w(3, 1, 0, 0), 6, 2, 5, 5);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(1);
        end
        check("t3_idle_cycle", 32'(rd_en), 0);
        tick();
        check("t3_first", 32'(rd_en), 4'b0001);
        drain("t3");
        check("t3_vc2_untouched", 32'(cnt[2]), 5);
        check("t3_vc3_untouched", 32'(cnt[3]), 5);

        // Pause after 2nd of 4 vc0 reads: credit held, then 2 more vc0, then vc1.
        start_test(pack_w(4, 1, 0, 0), 4, 1, 0, 0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        check("t4_rd1", 32'(rd_en), 4'b0001);
        tick();
        check("t4_rd2", 32'(rd_en), 4'b0001);
        tick();
        pause = 1'b1;
        #1;
        check("t4_pause1", 32'(rd_en), 0);
        tick();
        check("t4_pause2", 32'(rd_en), 0);
        tick();
        pause = 1'b0;
        #1;
        check("t4_rd3", 32'(rd_en), 4'b0001);
        tick();
        check("t4_rd4", 32'(rd_en), 4'b0001);
        tick();
        check("t4_rotate_vc1", 32'(rd_en), 4'b0010);
        drain("t4");

        // vc1 runs dry with credit left: one bubble, then vc2.
        start_test(pack_w(1, 4, 1, 0), 0, 2, 1, 0);
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(2);
        check("t5_idle_cycle", 32'(rd_en), 0);
        tick();
        check("t5_rd1", 32'(rd_en), 4'b0010);
        tick();
        check("t5_rd2", 32'(rd_en), 4'b0010);
        tick();
        check("t5_bubble", 32'(rd_en), 0);
        tick();
        check("t5_vc2", 32'(rd_en), 4'b0100);
        drain("t5");

        // init while serving vc2: no read that cycle, restart at vc0 with 2 reads each.
        start_test(pack_w(3, 3, 3, 3), 0, 0, 8, 0);
        exp_q.push_back(2);
        check("t6_idle_cycle", 32'(rd_en), 0);
        tick();
        check("t6_serve_vc2", 32'(rd_en), 4'b0100);
        tick();
        init    = 1'b1;
        weights = pack_w(2, 2, 2, 2);
        set_counts(4, 4, 4, 4);
        load = 1'b1;
        #1;
        check("t6_init_no_read", 32'(rd_en), 0);
        tick();
        init = 1'b0;
        load = 1'b0;
        #1;
        check("t6_idle_after_init", 32'(rd_en), 0);
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < 4; v++) begin
                exp_q.push_back(v);
                exp_q.push_back(v);
            end
        tick();
        check("t6_vc0_a", 32'(rd_en), 4'b0001);
        tick();
        check("t6_vc0_b", 32'(rd_en), 4'b0001);
        tick();
        check("t6_vc1", 32'(rd_en), 4'b0010);
        drain("t6");
        check("t6_final_idle", 32'(idle), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
